// File: rtl/music_pkg.sv
// Shared types and constants for the voice mixer: FSM state encoding,
// default sample width and the accumulator guard bits.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCUM,
    FINISH
  } mix_state_e;

  localparam int SAMPLE_W_DEF = 16;
  localparam int ACC_GUARD    = 3;

endpackage

// File: rtl/mix_beat_counter.sv
// Counts enable pulses and emits a one-cycle beat pulse on every BEAT_COUNT-th,
// wrapping back to zero; holds its count while en is low.
module mix_beat_counter
  import music_pkg::*;
#(
  parameter int BEAT_COUNT = 1000,
  parameter int CNT_W      = $clog2(BEAT_COUNT)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic beat
);

  logic [CNT_W-1:0] cnt_q;
  logic             beat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      if (en) begin
        if (cnt_q == CNT_W'(BEAT_COUNT - 1)) begin
          cnt_q  <= '0;
          beat_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign beat = beat_q;

endmodule

// File: rtl/multi_voice_mixer.sv
// Frame-driven mixer: requests one sample per active voice, sums them serially and
// presents the result on the next frame. MULTI_VOICE_MIXER_SAT_EN selects saturation over wrap.
module multi_voice_mixer
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int BEAT_COUNT = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           new_frame,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  output logic [NUM_VOICES-1:0]          gen_next,
  output logic [SAMPLE_W-1:0]            sample_out,
  output logic                           new_sample_generated,
  output logic                           beat,
  output logic                           late,
  output logic                           clip
);

  localparam int ACC_W  = SAMPLE_W + ACC_GUARD;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int BEAT_W = $clog2(BEAT_COUNT);

  mix_state_e              state_q;
  logic [NUM_VOICES-1:0]   act_q, rdy_q, gen_q, rdy_d;
  logic [IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0] acc_q, addend;
  logic [SAMPLE_W-1:0]     pending_q, out_q, pend_d;
  logic                    nsg_q, late_q, clip_q, clip_d, beat_en;

  assign rdy_d = rdy_q | (voice_ready & act_q);

  always_comb begin
    addend = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (int'(idx_q) == i && act_q[i]) begin
        addend = ACC_W'($signed(voice_sample[i*SAMPLE_W +: SAMPLE_W]));
      end
    end
  end

  always_comb begin
    pend_d = acc_q[SAMPLE_W-1:0];
    clip_d = 1'b0;
`ifdef MULTI_VOICE_MIXER_SAT_EN
    if (acc_q > $signed({{(ACC_GUARD+1){1'b0}}, {(SAMPLE_W-1){1'b1}}})) begin
      pend_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
      clip_d = 1'b1;
    end else if (acc_q < $signed({{(ACC_GUARD+1){1'b1}}, {(SAMPLE_W-1){1'b0}}})) begin
      pend_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
      clip_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      act_q     <= '0;
      rdy_q     <= '0;
      gen_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      pending_q <= '0;
      out_q     <= '0;
      nsg_q     <= 1'b0;
      late_q    <= 1'b0;
      clip_q    <= 1'b0;
    end else begin
      gen_q  <= '0;
      nsg_q  <= 1'b0;
      late_q <= 1'b0;
      clip_q <= 1'b0;
      if (new_frame) begin
        out_q  <= pending_q;
        nsg_q  <= 1'b1;
        late_q <= (state_q != IDLE);
        gen_q  <= voice_active & {NUM_VOICES{play}};
        act_q  <= voice_active;
        rdy_q  <= '0;
        if (!play || voice_active == '0) begin
          pending_q <= '0;
          state_q   <= IDLE;
        end else begin
          state_q <= WAIT;
        end
      end else begin
        case (state_q)
          // gen_q is non-zero only in the first WAIT cycle; ready seen then is too early.
          WAIT: begin
            if (gen_q == '0) begin
              rdy_q <= rdy_d;
              if ((rdy_d & act_q) == act_q) begin
                state_q <= ACCUM;
                idx_q   <= '0;
                acc_q   <= '0;
              end
            end
          end
          ACCUM: begin
            acc_q <= acc_q + addend;
            idx_q <= idx_q + IDX_W'(1);
            if (int'(idx_q) == NUM_VOICES - 1) state_q <= FINISH;
          end
          FINISH: begin
            pending_q <= pend_d;
            clip_q    <= clip_d;
            state_q   <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign beat_en = nsg_q & play;

  mix_beat_counter #(
    .BEAT_COUNT(BEAT_COUNT),
    .CNT_W     (BEAT_W)
  ) u_beat (
    .clk  (clk),
    .reset(reset),
    .en   (beat_en),
    .beat (beat)
  );

  assign gen_next             = gen_q;
  assign sample_out           = out_q;
  assign new_sample_generated = nsg_q;
  assign late                 = late_q;
  assign clip                 = clip_q;

endmodule

// File: tb/tb_multi_voice_mixer.sv
// Directed bench for multi_voice_mixer with a frame-level reference model.
module tb_multi_voice_mixer;

  localparam int NV = 3;
  localparam int SW = 16;
  localparam int BC = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           play = 1'b0;
  logic           new_frame = 1'b0;
  logic [NV-1:0]  voice_active = '0;
  logic [NV-1:0]  voice_ready = '0;
  logic [NV*SW-1:0] voice_sample = '0;
  logic [NV-1:0]  gen_next;
  logic [SW-1:0]  sample_out;
  logic           nsg, beat, late, clip;

  int total = 0;
  int bad = 0;
  int n_nsg = 0, n_late = 0, n_clip = 0, n_beat = 0;

  // reference model state
  logic [SW-1:0] m_pending = '0, e_out = '0;
  logic [NV-1:0] m_mask = '0, m_got = '0, e_gen = '0, t_gen;
  bit m_busy = 0, m_waiting = 0, m_first = 0;
  bit e_nsg = 0, e_late = 0, e_clip = 0, e_beat = 0;
  bit t_nsg, t_late, t_clip, t_beat;
  int m_left = 0, m_bcnt = 0, m_sum;

  always #5 clk = ~clk;

  multi_voice_mixer #(
    .NUM_VOICES(NV),
    .SAMPLE_W  (SW),
    .BEAT_COUNT(BC)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .play                (play),
    .new_frame           (new_frame),
    .voice_active        (voice_active),
    .voice_sample        (voice_sample),
    .voice_ready         (voice_ready),
    .gen_next            (gen_next),
    .sample_out          (sample_out),
    .new_sample_generated(nsg),
    .beat                (beat),
    .late                (late),
    .clip                (clip)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a mix job completes NV+1 edges after every active voice has reported.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pending = '0; e_out = '0; e_gen = '0;
        m_busy = 0; m_waiting = 0; m_first = 0; m_left = 0; m_bcnt = 0;
        e_nsg = 0; e_late = 0; e_clip = 0; e_beat = 0;
      end else begin
        t_beat = 0; t_clip = 0; t_nsg = 0; t_late = 0; t_gen = '0;
        if (e_nsg && play) begin
          m_bcnt++;
          if (m_bcnt == BC) begin
            m_bcnt = 0;
            t_beat = 1;
          end
        end
        if (new_frame) begin
          t_late = m_busy;
          e_out  = m_pending;
          t_nsg  = 1;
          t_gen  = voice_active & {NV{play}};
          if (!play || voice_active == '0) begin
            m_pending = '0;
            m_busy = 0;
            m_waiting = 0;
          end else begin
            m_busy = 1; m_waiting = 1; m_first = 1;
            m_mask = voice_active; m_got = '0;
          end
        end else if (m_busy) begin
          if (m_waiting) begin
            if (!m_first) m_got = m_got | (voice_ready & m_mask);
            m_first = 0;
            if (m_got == m_mask) begin
              m_waiting = 0;
              m_left = NV + 1;
            end
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_sum = 0;
              for (int i = 0; i < NV; i++)
                if (m_mask[i]) m_sum += int'($signed(voice_sample[i*SW +: SW]));
              m_pending = m_sum[SW-1:0];
`ifdef MULTI_VOICE_MIXER_SAT_EN
              if (m_sum > (1 << (SW-1)) - 1) begin
                m_pending = {1'b0, {(SW-1){1'b1}}};
                t_clip = 1;
              end else if (m_sum < -(1 << (SW-1))) begin
                m_pending = {1'b1, {(SW-1){1'b0}}};
                t_clip = 1;
              end
`endif
              m_busy = 0;
            end
          end
        end
        e_gen = t_gen; e_nsg = t_nsg; e_late = t_late; e_clip = t_clip; e_beat = t_beat;
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("sample_out", 32'(sample_out), 32'(e_out));
      check("gen_next", 32'(gen_next), 32'(e_gen));
      check("new_sample_generated", 32'(nsg), 32'(e_nsg));
      check("late", 32'(late), 32'(e_late));
      check("clip", 32'(clip), 32'(e_clip));
      check("beat", 32'(beat), 32'(e_beat));
      if (nsg === 1'b1) n_nsg++;
      if (late === 1'b1) n_late++;
      if (clip === 1'b1) n_clip++;
      if (beat === 1'b1) n_beat++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  // called in the gen_next cycle; ready is sampled d cycles after gen_next
  task automatic serve(input logic [NV-1:0] m, input int d);
    repeat (d) tick();
    voice_ready = m;
    tick();
    voice_ready = '0;
    repeat (NV + 3) tick();
  endtask

  task automatic set_samples(input int a, input int b, input int c);
    voice_sample = {SW'(c), SW'(b), SW'(a)};
  endtask

  logic [SW-1:0] exp2;
  int exp2_clip;
  int c0;

  initial begin
`ifdef MULTI_VOICE_MIXER_SAT_EN
    exp2 = 16'h7FFF;
    exp2_clip = 1;
`else
    exp2 = 16'h7FFD;
    exp2_clip = 0;
`endif
    repeat (2) tick();
    check("reset_sample_out", 32'(sample_out), 32'd0);
    check("reset_pulses", 32'({gen_next, nsg, late, clip, beat}), 32'd0);
    reset = 1'b1;
    tick();

    // case 1: 1000 + 2000 - 500, ready 5 cycles after gen_next
    play = 1'b1;
    voice_active = 3'b111;
    set_samples(1000, 2000, -500);
    frame();
    serve(3'b111, 5);
    c0 = n_nsg;
    frame();
    check("c1_sample_out", 32'(sample_out), 32'd2500);

    // case 2: three full-scale voices
    set_samples(32767, 32767, 32767);
    serve(3'b111, 2);
    check("c1_single_nsg", 32'(n_nsg - c0), 32'd1);
    c0 = n_clip;
    frame();
    check("c2_sample_out", 32'(sample_out), 32'(exp2));
    check("c2_clip_count", 32'(n_clip - c0), 32'(exp2_clip));

    // case 3: voice 1 never ready -> late, output holds previous mix
    set_samples(100, 200, 300);
    serve(3'b101, 2);
    c0 = n_late;
    frame();
    check("c3_hold", 32'(sample_out), 32'(exp2));
    serve(3'b111, 1);
    check("c3_late_count", 32'(n_late - c0), 32'd1);
    frame();
    check("c3_recover", 32'(sample_out), 32'd600);

    // ready in the gen_next cycle is ignored, so the mix never completes
    serve(3'b111, 0);
    c0 = n_late;
    frame();
    check("c3b_hold", 32'(sample_out), 32'd600);

    // case 5: reset while accumulating
    set_samples(10, 20, 30);
    tick();
    check("c3b_late_count", 32'(n_late - c0), 32'd1);
    voice_ready = 3'b111;
    tick();
    voice_ready = '0;
    tick();
    reset = 1'b0;
    #1;
    check("c5_rst_sample_out", 32'(sample_out), 32'd0);
    check("c5_rst_pulses", 32'({gen_next, nsg, late, clip, beat}), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    c0 = n_late;
    frame();
    check("c5_first_frame", 32'(sample_out), 32'd0);
    serve(3'b111, 1);
    frame();
    check("c5_mix", 32'(sample_out), 32'd60);
    serve(3'b111, 1);

    // partial mask, sampled at the frame: voices 0 and 2 only
    voice_active = 3'b101;
    set_samples(1000, 2000, -500);
    frame();
    check("mask_prev", 32'(sample_out), 32'd60);
    serve(3'b101, 3);
    frame();
    check("mask_mix", 32'(sample_out), 32'd500);
    serve(3'b101, 1);
    check("c5_no_late", 32'(n_late - c0), 32'd0);

    // case 4: beats with play gating
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    voice_active = '0;
    play = 1'b1;
    c0 = n_beat;
    for (int k = 0; k < 8; k++) begin frame(); repeat (3) tick(); end
    play = 1'b0;
    for (int k = 0; k < 3; k++) begin frame(); repeat (3) tick(); end
    check("c4_silence", 32'(sample_out), 32'd0);
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin frame(); repeat (3) tick(); end
    repeat (3) tick();
    check("c4_beat_count", 32'(n_beat - c0), 32'd3);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_voice_mixer.md
MULTI_VOICE_MIXER -- requirements
Module: multi_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of sample sources mixed (1..8).
REQ-002 SHALL have parameter SAMPLE_W, default 16, signed sample width.
REQ-003 SHALL have parameter BEAT_COUNT, default 1000, frames per beat (≥2; reduced in simulation).
REQ-004 SHALL have ports: clk  in  1  system clock; all logic is single-clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port play  in  1  high = mix and advance beats; low = silence.
REQ-007 SHALL have port new_frame  in  1  one-cycle codec frame strobe (48 kHz).
REQ-008 SHALL have port voice_active  in  NUM_VOICES  per-voice enable mask.
REQ-009 SHALL have port voice_sample  in  NUM_VOICES*SAMPLE_W  packed signed voice samples; voice i at bits [i*SAMPLE_W +: SAMPLE_W].
REQ-010 SHALL have port voice_ready  in  NUM_VOICES  one-cycle pulse per voice, sample valid.
REQ-011 SHALL have port gen_next  out  NUM_VOICES  one-cycle request for next voice sample.
REQ-012 SHALL have port sample_out  out  SAMPLE_W  mixed sample, changes only on new_frame.
REQ-013 SHALL have port new_sample_generated  out  1  one-cycle pulse when sample_out loads.
REQ-014 SHALL have port beat  out  1  one-cycle pulse every BEAT_COUNT generated samples.
REQ-015 SHALL have port late  out  1  one-cycle pulse when a frame arrives before the mix completes.
REQ-016 SHALL have port clip  out  1  one-cycle pulse when the mix saturated.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ACCUM, FINISH.
REQ-018 On new_frame, in any state: sample_out <= pending, new_sample_generated = 1 in the following cycle, gen_next = voice_active & {NUM_VOICES{play}}, ready latches cleared, state -> WAIT.
REQ-019 new_frame in a state other than IDLE SHALL pulse late, abort the current mix, and keep pending unchanged.
REQ-020 WAIT SHALL OR voice_ready into ready latches, ignoring inactive voices. When every active voice is latched, the state SHALL go to ACCUM.
REQ-021 voice_ready arriving in the same cycle as gen_next SHALL be ignored; the minimum voice latency is 1 cycle.
REQ-022 ACCUM SHALL add one voice per cycle, index 0..NUM_VOICES-1, into an accumulator of width SAMPLE_W+3. Inactive voices SHALL add 0. After the last index, the state SHALL go to FINISH.
REQ-023 FINISH SHALL load pending from the accumulator (REQ-030) and then go to IDLE. The mix latency from the last ready to pending SHALL be NUM_VOICES+1 cycles.
REQ-024 If play is low, or voice_active is all zero, at new_frame, the FSM SHALL skip WAIT/ACCUM, load pending = 0, and return to IDLE.
REQ-025 The beat counter SHALL count new_sample_generated pulses while play is high, hold its value while play is low, and pulse beat and wrap to 0 at BEAT_COUNT-1.
REQ-026 A voice_active change mid-mix SHALL take effect at the next new_frame; the mask SHALL be sampled at new_frame.

Reset
REQ-027 On reset low, asynchronously: state=IDLE, sample_out=0, pending=0, accumulator=0, beat counter=0, and all pulse outputs=0.
REQ-028 A reset released mid-mix SHALL restart cleanly at the next new_frame, with no spurious gen_next.

Configuration
REQ-029 Macro MULTI_VOICE_MIXER_SAT_EN SHALL select the overflow behaviour.
REQ-030 With the macro defined, the accumulator SHALL saturate to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], and clip SHALL pulse with the FINISH load when a saturation occurs. Without the macro, the low SAMPLE_W bits SHALL be taken (wrap) and clip SHALL be tied to 0.

Structure
REQ-031 Package music_pkg SHALL hold the mixer state enum, the default SAMPLE_W, and the ACC_GUARD=3 constant.
REQ-032 The beat counter SHALL be a sub-module mix_beat_counter (parameters BEAT_COUNT and width; ports en and beat).

Verification
REQ-033 Case 1 (3 voices all active, samples 1000/2000/-500, ready 5 cycles after gen_next): next frame -> sample_out=2500, with a single new_sample_generated pulse.
REQ-034 Case 2 (3 voices at 0x7FFF, macro defined): next frame -> sample_out=0x7FFF with clip pulsed once. With the macro undefined, the same stimulus -> sample_out=0x7FFD and clip=0.
REQ-035 Case 3 (voice 1 never asserts ready): next frame -> late pulses and sample_out holds the previous mix.
REQ-036 Case 4 (BEAT_COUNT=4, play high for 8 frames, then low for 3, then high for 4): exactly 3 beat pulses.
REQ-037 Case 5 (reset asserted during ACCUM): all outputs 0 immediately; after release and two frames, the mix is correct with no late pulse.
